// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-packed-BCD converter.
// One input bit per clock, framed by a start/busy/done handshake.
`default_nettype none

module bin_to_bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [BIN_W-1:0]    shift_reg;
  logic [4*DIGITS-1:0] scratch;
  logic [4*DIGITS-1:0] adjusted;
  logic [4*DIGITS-1:0] scratch_next;
  logic                carry;
  logic                ovf_acc;
  logic [CNT_W-1:0]    count;
  logic                last_iter;

  always_comb begin
    adjusted = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
    {carry, scratch_next} = {adjusted, shift_reg[BIN_W-1]};
  end

  assign last_iter = (count == CNT_W'(1));

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The result registers are written on the final iteration edge so they are
  // valid for the whole cycle in which done is high.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      shift_reg <= '0;
      scratch   <= '0;
      ovf_acc   <= 1'b0;
      count     <= '0;
      bcd_out   <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= bin_in;
            scratch   <= '0;
            ovf_acc   <= 1'b0;
            count     <= CNT_W'(BIN_W);
          end
        end
        SHIFT: begin
          shift_reg <= {shift_reg[BIN_W-2:0], 1'b0};
          scratch   <= scratch_next;
          ovf_acc   <= ovf_acc | carry;
          count     <= count - CNT_W'(1);
          if (last_iter) begin
            bcd_out  <= scratch_next;
            overflow <= ovf_acc | carry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-and-add-3 (double dabble). It is the reverse of the decimal-to-binary path: it turns the binary result back into packed BCD digits for the seven-segment display scanner. One bit is processed per clock, and a start/busy/done handshake frames each conversion. The block runs in the fast system clock domain. The display refresh logic reads `bcd_out` asynchronously to each conversion.

Parameters:
- BIN_W, 16, width of the binary input, in bits (≥ 2).
- DIGITS, 5, number of BCD digits produced; `bcd_out` width is 4*DIGITS.

Ports:
- clk_in, input, 1, system clock; all state updates on its rising edge.
- rst, input, 1, asynchronous active-low reset (rst==0 resets immediately).
- start, input, 1, conversion request; sampled only in IDLE.
- bin_in, input, BIN_W, binary operand; captured on the accepted start edge.
- busy, output, 1, high while a conversion is in progress (SHIFT state).
- done, output, 1, single-cycle pulse when `bcd_out`/`overflow` update.
- bcd_out, output, 4*DIGITS, packed BCD result; digit 0 (units) in bits [3:0].
- overflow, output, 1, high when bin_in > 10^DIGITS − 1; `bcd_out` then holds bin_in mod 10^DIGITS.

Behaviour:
- Reset (rst==0, asynchronous):
  - state = IDLE.
  - busy = 0, done = 0, bcd_out = 0, overflow = 0.
  - Internal shift register, scratch BCD register and bit counter all cleared.
- State IDLE:
  - start==1 at a rising edge: capture bin_in into the shift register, clear the scratch BCD register and overflow accumulator, load counter = BIN_W, go to SHIFT.
  - start==0: remain in IDLE.
- State SHIFT (busy=1), one iteration per cycle:
  - Every scratch digit ≥ 5 gets +3 (combinational).
  - {carry, scratch, shift} is then shifted left by 1; the MSB of the shift register enters scratch bit 0.
  - The carry leaving the top digit is ORed into the overflow accumulator.
  - Counter decrements each cycle. When the counter reaches 1 on an iteration, go to DONE after that iteration (exactly BIN_W SHIFT cycles).
- State DONE (one cycle):
  - bcd_out ← scratch, overflow ← accumulator, done = 1, busy = 0.
  - Next state is IDLE.
- Latency:
  - start sampled at edge N → busy high from N to N+BIN_W.
  - done high for the cycle after edge N+BIN_W.
  - bcd_out valid from that same edge.
  - Next start is accepted at edge N+BIN_W+2 at the earliest.
- Holding and ignoring inputs:
  - bcd_out and overflow hold their value between done pulses and do not change during SHIFT.
  - start while busy or in DONE is ignored; no queueing.
  - bin_in changes after capture have no effect.
- Arithmetic rules:
  - Each scratch digit stays in 0..9 after every iteration.
  - The add-3 is applied to all DIGITS digits in parallel, before the shift, in the same cycle.
- Reset mid-conversion:
  - Aborts the conversion; outputs return to reset values.
  - No done pulse is generated for the aborted conversion.
- Start held high continuously: a new conversion begins every BIN_W+2 cycles.

Test Plan:
1. Defaults, bin_in=0, one-cycle start → done exactly 17 cycles after the start edge; bcd_out=0x00000, overflow=0; busy high for 16 cycles.
2. bin_in=16'd65535 → bcd_out=0x65535, overflow=0. Then bin_in=16'd1234 → bcd_out=0x01234; the previous value holds until the new done.
3. Start pulsed again 5 cycles after an accepted start with a different bin_in → ignored; the result matches the first operand; exactly one done pulse.
4. rst asserted low at SHIFT cycle 8 → busy, done, bcd_out, overflow all 0 immediately; after release, idle with no spurious done.
5. BIN_W=8, DIGITS=2, bin_in=8'd255 → bcd_out=0x55, overflow=1. Then bin_in=8'd99 → bcd_out=0x99, overflow=0.
6. Start held high for 60 cycles with bin_in=16'd9 → done pulses every 18 cycles; bcd_out=0x00009 each time.
